// File: rtl/arm_pkg.sv
// arm_pkg: shared types and constants for the block transfer sequencer.
package arm_pkg;
  typedef enum logic [1:0] {IDLE, XFER, WB, DONE} bts_state_t;
  typedef enum logic [1:0] {DA = 2'b00, IA = 2'b01, DB = 2'b10, IB = 2'b11} addr_mode_t;
  localparam logic [31:0] WORD_BYTES = 32'd4;
  localparam logic [3:0] PC_REG = 4'd15;
endpackage

// File: rtl/lowest_set_bit.sv
// lowest_set_bit: index of the lowest set bit of a 16-bit list, with an empty flag.
module lowest_set_bit (
  input  logic [15:0] list,
  output logic [3:0]  idx,
  output logic        none
);
  always_comb begin
    idx = '0;
    for (int i = 15; i >= 0; i--) idx = list[i] ? 4'(i) : idx;
    none = ~|list;
  end
endmodule

// File: rtl/block_transfer_sequencer.sv
// block_transfer_sequencer: LDM/STM register-list walker driving memory and the register file.
// Base writeback (WB state, W bit) is built only when BTS_BASE_WRITEBACK_EN is defined.
module block_transfer_sequencer
  import arm_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_load,
  input  logic              pre_index,
  input  logic              up,
  input  logic              writeback,
  input  logic [3:0]        base_reg,
  input  logic [DATA_W-1:0] base_addr,
  input  logic [15:0]       reg_list,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_write_enable,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [3:0]        read_reg_addrs,
  input  logic [DATA_W-1:0] read_datas,
  output logic              write_enable3,
  output logic [3:0]        write_reg_addr3,
  output logic [DATA_W-1:0] write_data3,
  output logic              pc_load_valid,
  output logic [DATA_W-1:0] pc_load_data
);
`ifdef BTS_BASE_WRITEBACK_EN
  localparam bit WB_BUILT = 1'b1;
`else
  localparam bit WB_BUILT = 1'b0;
`endif
  bts_state_t        state;
  addr_mode_t        mode;
  logic [15:0]       list, list_nxt;
  logic [3:0]        cur, base_reg_r;
  logic [4:0]        n;
  logic [DATA_W-1:0] n4, start_addr, final_base;
  logic              none, load_r, wb_r, wb_write_r, xfer, in_wb, hs, last;
  lowest_set_bit u_lsb (.list(list), .idx(cur), .none(none));
  always_comb begin
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(reg_list[i]);
    n4 = DATA_W'({n, 2'b00});
    mode = addr_mode_t'({pre_index, up});
    start_addr = mode == IA ? base_addr :
                 mode == IB ? base_addr + WORD_BYTES :
                 mode == DA ? base_addr - n4 + WORD_BYTES : base_addr - n4;
  end
  assign xfer     = state == XFER;
  assign in_wb    = state == WB;
  // a beat being cut off by reset must not reach the register file
  assign hs       = xfer & mem_ready & ~none & ~reset;
  assign list_nxt = list & ~(16'd1 << cur);
  assign last     = ~|list_nxt;
  assign busy             = state != IDLE;
  assign done             = state == DONE;
  assign mem_req          = xfer;
  assign mem_write_enable = xfer & ~load_r;
  assign mem_write_data   = mem_write_enable ? read_datas : '0;
  assign read_reg_addrs   = cur;
  assign write_enable3    = (hs & load_r & cur != PC_REG) | (in_wb & wb_write_r & ~reset);
  assign write_reg_addr3  = in_wb ? base_reg_r : (xfer & load_r) ? cur : '0;
  assign write_data3      = in_wb ? final_base : (xfer & load_r) ? mem_read_data : '0;
  assign pc_load_valid    = hs & load_r & cur == PC_REG;
  assign pc_load_data     = pc_load_valid ? mem_read_data : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      list       <= '0;
      mem_addr   <= '0;
      load_r     <= 1'b0;
      wb_r       <= 1'b0;
      wb_write_r <= 1'b0;
      base_reg_r <= '0;
      final_base <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state      <= reg_list == '0 ? DONE : XFER;
          list       <= reg_list;
          mem_addr   <= start_addr;
          load_r     <= is_load;
          wb_r       <= writeback & WB_BUILT;
          base_reg_r <= base_reg;
          final_base <= up ? base_addr + n4 : base_addr - n4;
          wb_write_r <= base_reg != PC_REG && !(is_load && reg_list[base_reg]);
        end
        XFER: if (hs) begin
          list     <= list_nxt;
          mem_addr <= mem_addr + WORD_BYTES;
          if (last) state <= wb_r ? WB : DONE;
        end
        WB:      state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_block_transfer_sequencer.sv
// tb_block_transfer_sequencer: directed scenarios for the LDM/STM sequencer.
module tb_block_transfer_sequencer;
`ifdef BTS_BASE_WRITEBACK_EN
  localparam int WB = 1;
`else
  localparam int WB = 0;
`endif
  logic clk = 0, reset = 1, start = 0, is_load = 0, pre_index = 0, up = 0, writeback = 0, mem_ready = 0;
  logic [3:0] base_reg = '0;
  logic [31:0] base_addr = '0;
  logic [15:0] reg_list = '0;
  logic busy, done, mem_req, mem_write_enable, write_enable3, pc_load_valid;
  logic [31:0] mem_addr, mem_write_data, mem_read_data, read_datas, write_data3, pc_load_data;
  logic [3:0] read_reg_addrs, write_reg_addr3;
  logic [31:0] b_addr[$], b_wd[$], w_data[$], pc_q[$], s_addr[$], s_wd[$];
  logic b_we[$], s_we[$];
  logic [3:0] w_addr[$], s_rr[$];
  int cyc = 0, checks = 0, errors = 0;

  block_transfer_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .is_load(is_load), .pre_index(pre_index), .up(up),
    .writeback(writeback), .base_reg(base_reg), .base_addr(base_addr), .reg_list(reg_list),
    .busy(busy), .done(done), .mem_req(mem_req), .mem_write_enable(mem_write_enable),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_ready(mem_ready),
    .mem_read_data(mem_read_data), .read_reg_addrs(read_reg_addrs), .read_datas(read_datas),
    .write_enable3(write_enable3), .write_reg_addr3(write_reg_addr3), .write_data3(write_data3),
    .pc_load_valid(pc_load_valid), .pc_load_data(pc_load_data)
  );

  always #5 clk = ~clk;
  assign mem_read_data = mem_addr ^ 32'hDEAD_0000;
  assign read_datas    = 32'hCAFE_0000 | {28'd0, read_reg_addrs};
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mem_req && mem_ready) begin b_addr.push_back(mem_addr); b_we.push_back(mem_write_enable); b_wd.push_back(mem_write_data); end
    if (mem_req && !mem_ready) begin s_addr.push_back(mem_addr); s_we.push_back(mem_write_enable); s_rr.push_back(read_reg_addrs); s_wd.push_back(mem_write_data); end
    if (write_enable3) begin w_addr.push_back(write_reg_addr3); w_data.push_back(write_data3); end
    if (pc_load_valid) pc_q.push_back(pc_load_data);
  end

  task automatic clear_q;
    b_addr.delete(); b_wd.delete(); b_we.delete(); w_addr.delete(); w_data.delete(); pc_q.delete();
    s_addr.delete(); s_wd.delete(); s_we.delete(); s_rr.delete();
  endtask

  task automatic run_cmd(input logic ld, input logic p, input logic u, input logic w, input logic [3:0] br,
                         input logic [31:0] ba, input logic [15:0] rl, input int sb, input int sl, output int lat);
    int beats, stalls, t0;
    @(posedge clk); #1;
    is_load = ld; pre_index = p; up = u; writeback = w; base_reg = br; base_addr = ba; reg_list = rl;
    start = 1; mem_ready = 1;
    clear_q();
    t0 = cyc; beats = 0; stalls = 0; lat = -1;
    for (int k = 0; k < 60 && lat < 0; k++) begin
      @(posedge clk); #1;
      start = 0;
      mem_ready = !(beats == sb && stalls < sl);
      @(negedge clk);
      if (mem_req && mem_ready) beats++;
      if (mem_req && !mem_ready) stalls++;
      if (done) lat = cyc - t0;
    end
    checks++; if (lat < 0) begin errors++; $display("FAIL done_timeout got none want done within 60 cycles"); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_done got %b want 0", busy); end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({busy, done, mem_req, mem_write_enable, write_enable3, pc_load_valid} !== 6'b0) begin errors++; $display("FAIL reset_flags got %b want 000000", {busy, done, mem_req, mem_write_enable, write_enable3, pc_load_valid}); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    checks++; if ({mem_write_data, write_data3, pc_load_data} !== 96'h0) begin errors++; $display("FAIL reset_data got %h %h %h want 0", mem_write_data, write_data3, pc_load_data); end
    checks++; if ({read_reg_addrs, write_reg_addr3} !== 8'h0) begin errors++; $display("FAIL reset_reg_addrs got %h %h want 0", read_reg_addrs, write_reg_addr3); end
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic test_stm_ia;
    int lat;
    logic [31:0] ea[3] = '{32'h1000, 32'h1004, 32'h1008};
    logic [31:0] ed[3] = '{32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003};
    run_cmd(0, 0, 1, 1, 4'd5, 32'h1000, 16'h000E, -1, 0, lat);
    checks++; if (b_addr.size() !== 3) begin errors++; $display("FAIL stm_ia_beats got %0d want 3", b_addr.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (b_addr[i] !== ea[i] || b_wd[i] !== ed[i] || b_we[i] !== 1'b1) begin errors++; $display("FAIL stm_ia_beat%0d got %h/%h/%b want %h/%h/1", i, b_addr[i], b_wd[i], b_we[i], ea[i], ed[i]); end
    end
    checks++; if (w_addr.size() !== WB) begin errors++; $display("FAIL stm_ia_wb_count got %0d want %0d", w_addr.size(), WB); end
    if (w_addr.size() > 0) begin
      checks++; if (w_addr[0] !== 4'd5 || w_data[0] !== 32'h100C) begin errors++; $display("FAIL stm_ia_wb got r%0d=%h want r5=0000100c", w_addr[0], w_data[0]); end
    end
    checks++; if (lat !== 4 + WB) begin errors++; $display("FAIL stm_ia_latency got %0d want %0d", lat, 4 + WB); end
  endtask

  task automatic test_ldm_db;
    int lat;
    run_cmd(1, 1, 0, 0, 4'd4, 32'h2000, 16'h8003, -1, 0, lat);
    checks++; if (b_addr.size() !== 3 || b_addr[0] !== 32'h1FF4 || b_addr[1] !== 32'h1FF8 || b_addr[2] !== 32'h1FFC) begin errors++; $display("FAIL ldm_db_addrs got %0d beats first %h want 3 beats 1ff4,1ff8,1ffc", b_addr.size(), b_addr[0]); end
    checks++; if (b_we[0] !== 1'b0 || b_we[2] !== 1'b0) begin errors++; $display("FAIL ldm_db_we got %b %b want 0 0", b_we[0], b_we[2]); end
    checks++; if (w_addr.size() !== 2) begin errors++; $display("FAIL ldm_db_wr_count got %0d want 2", w_addr.size()); end
    checks++; if (w_addr[0] !== 4'd0 || w_data[0] !== 32'hDEAD1FF4) begin errors++; $display("FAIL ldm_db_r0 got r%0d=%h want r0=dead1ff4", w_addr[0], w_data[0]); end
    checks++; if (w_addr[1] !== 4'd1 || w_data[1] !== 32'hDEAD1FF8) begin errors++; $display("FAIL ldm_db_r1 got r%0d=%h want r1=dead1ff8", w_addr[1], w_data[1]); end
    checks++; if (pc_q.size() !== 1 || pc_q[0] !== 32'hDEAD1FFC) begin errors++; $display("FAIL ldm_db_pc got %0d loads %h want 1 load dead1ffc", pc_q.size(), pc_q[0]); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL ldm_db_latency got %0d want 4", lat); end
  endtask

  task automatic test_base_in_list;
    int lat;
    run_cmd(1, 0, 1, 1, 4'd2, 32'h3000, 16'h0004, -1, 0, lat);
    checks++; if (w_addr.size() !== 1) begin errors++; $display("FAIL bil_wr_count got %0d want 1", w_addr.size()); end
    checks++; if (w_addr[0] !== 4'd2 || w_data[0] !== 32'hDEAD3000) begin errors++; $display("FAIL bil_load got r%0d=%h want r2=dead3000", w_addr[0], w_data[0]); end
    checks++; if (lat !== 2 + WB) begin errors++; $display("FAIL bil_latency got %0d want %0d", lat, 2 + WB); end
  endtask

  task automatic test_empty;
    int lat;
    run_cmd(0, 0, 1, 1, 4'd3, 32'h7000, 16'h0000, -1, 0, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL empty_latency got %0d want 1", lat); end
    checks++; if (b_addr.size() + s_addr.size() !== 0) begin errors++; $display("FAIL empty_mem_req got %0d want 0", b_addr.size() + s_addr.size()); end
    checks++; if (w_addr.size() !== 0) begin errors++; $display("FAIL empty_write got %0d want 0", w_addr.size()); end
  endtask

  task automatic test_wait_states;
    int lat;
    logic [31:0] ea[3] = '{32'h4004, 32'h4008, 32'h400C};
    logic [31:0] ed[3] = '{32'hCAFE0000, 32'hCAFE0002, 32'hCAFE0004};
    run_cmd(0, 1, 1, 0, 4'd9, 32'h4000, 16'h0015, 1, 3, lat);
    checks++; if (b_addr.size() + s_addr.size() !== 6) begin errors++; $display("FAIL wait_beat_cycles got %0d want 6", b_addr.size() + s_addr.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (b_addr[i] !== ea[i] || b_wd[i] !== ed[i]) begin errors++; $display("FAIL wait_beat%0d got %h/%h want %h/%h", i, b_addr[i], b_wd[i], ea[i], ed[i]); end
      checks++; if (s_addr[i] !== 32'h4008 || s_rr[i] !== 4'd2 || s_we[i] !== 1'b1 || s_wd[i] !== 32'hCAFE0002) begin errors++; $display("FAIL wait_stall%0d got %h/r%0d/%b/%h want 00004008/r2/1/cafe0002", i, s_addr[i], s_rr[i], s_we[i], s_wd[i]); end
    end
    checks++; if (lat !== 7) begin errors++; $display("FAIL wait_latency got %0d want 7", lat); end
  endtask

  task automatic test_stm_da;
    int lat;
    run_cmd(0, 0, 0, 1, 4'd3, 32'h0100, 16'h0003, -1, 0, lat);
    checks++; if (b_addr.size() !== 2 || b_addr[0] !== 32'hFC || b_addr[1] !== 32'h100) begin errors++; $display("FAIL stm_da_addrs got %0d beats %h %h want 2 beats fc 100", b_addr.size(), b_addr[0], b_addr[1]); end
    checks++; if (b_wd[0] !== 32'hCAFE0000 || b_wd[1] !== 32'hCAFE0001) begin errors++; $display("FAIL stm_da_data got %h %h want cafe0000 cafe0001", b_wd[0], b_wd[1]); end
    checks++; if (w_addr.size() !== WB) begin errors++; $display("FAIL stm_da_wb_count got %0d want %0d", w_addr.size(), WB); end
    if (w_addr.size() > 0) begin
      checks++; if (w_addr[0] !== 4'd3 || w_data[0] !== 32'hF8) begin errors++; $display("FAIL stm_da_wb got r%0d=%h want r3=000000f8", w_addr[0], w_data[0]); end
    end
    checks++; if (lat !== 3 + WB) begin errors++; $display("FAIL stm_da_latency got %0d want %0d", lat, 3 + WB); end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    is_load = 1; pre_index = 0; up = 1; writeback = 1; base_reg = 4'd8; base_addr = 32'h5000; reg_list = 16'h00F0;
    start = 1; mem_ready = 1;
    clear_q();
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    reset = 1; mem_ready = 0;
    @(posedge clk); #1;
    reset = 0; mem_ready = 1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL rst_mid_idle got busy=%b mem_req=%b want 0 0", busy, mem_req); end
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (w_addr.size() !== 1 || w_addr[0] !== 4'd4 || w_data[0] !== 32'hDEAD5000) begin errors++; $display("FAIL rst_mid_writes got %0d writes first r%0d=%h want 1 write r4=dead5000", w_addr.size(), w_addr[0], w_data[0]); end
    checks++; if (b_addr.size() !== 1) begin errors++; $display("FAIL rst_mid_beats got %0d want 1", b_addr.size()); end
  endtask

  initial begin
    test_reset();
    test_stm_ia();
    test_ldm_db();
    test_base_in_list();
    test_empty();
    test_wait_states();
    test_stm_da();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/block_transfer_sequencer.md
# block_transfer_sequencer

Multi-cycle sequencer for ARM block data transfers (LDM/STM). It sits directly upstream of the register file. It walks a 16-bit register list in ascending order, issues one word memory access per listed register, and drives the register file write port (loads) or the store-data read port (stores). It then optionally writes back the updated base register. Decode hands it a command; it holds `busy` until the transfer completes.

## Interface
Parameters:
- `DATA_W`, 32: data/address width; only 32 is supported.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  command strobe; accepted only in IDLE.
- `is_load`  in  1  1 = LDM, 0 = STM.
- `pre_index`  in  1  P bit.
- `up`  in  1  U bit.
- `writeback`  in  1  W bit.
- `base_reg`  in  4  base register number.
- `base_addr`  in  32  base register value, sampled at accept.
- `reg_list`  in  16  register list, sampled at accept.
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle completion pulse.
- `mem_req`  out  1  memory beat valid.
- `mem_write_enable`  out  1  1 for STM beats.
- `mem_addr`  out  32  word address of the current beat.
- `mem_write_data`  out  32  store data, equal to `read_datas`.
- `mem_ready`  in  1  beat completes when `mem_req && mem_ready`.
- `mem_read_data`  in  32  load data, valid with `mem_ready`.
- `read_reg_addrs`  out  4  register-file store-data read address.
- `read_datas`  in  32  register-file store-data read value.
- `write_enable3`, `write_reg_addr3`, `write_data3`  out  1/4/32  register-file write port.
- `pc_load_valid`, `pc_load_data`  out  1/32  load to r15. The register file holds no r15, so these go to the PC logic instead.

## Operation
- States: IDLE, XFER, WB, DONE.
- IDLE → XFER on `start`. IDLE → DONE if `reg_list == 0`: no beats and no writeback.
- At accept:
  - N = popcount(`reg_list`).
  - Start address:
    - IA (P=0, U=1): base.
    - IB (P=1, U=1): base+4.
    - DA (P=0, U=0): base−4N+4.
    - DB (P=1, U=0): base−4N.
  - Final base value is base+4N if U=1, otherwise base−4N.
  - All arithmetic is modulo 2^32.
- XFER:
  - The current register is the lowest set bit of the remaining list.
  - `mem_addr` increments by 4 per completed beat, in every mode.
  - The current register's bit clears on each beat.
  - XFER → WB after the last beat if W=1. Otherwise XFER → DONE.
- Loads:
  - The write port fires combinationally in the handshake cycle, with `write_data3 = mem_read_data`.
  - For register 15, `pc_load_valid` fires instead and `write_enable3` stays 0.
- Stores:
  - `read_reg_addrs` = current register.
  - `mem_write_data` = `read_datas`, which is the unmodified base when the base is in the list.
- WB:
  - One cycle, `write_enable3=1`, `write_reg_addr3=base_reg`, data = final base.
  - Suppressed (WB passes with no write) when `base_reg==15`, or when `is_load` and the base is in the list (the loaded value wins).
- DONE: `done=1` for one cycle, then IDLE.
- `start` is ignored while `busy`.

## Timing
- Reset values: state IDLE; `busy`, `done`, `mem_req`, `mem_write_enable`, `write_enable3`, `pc_load_valid` all 0; all address and data outputs 0.
- Accept at cycle 0. `busy` and `mem_req` rise at cycle 1.
- With zero-wait memory, beats occur in cycles 1..N. WB, if present, is cycle N+1. `done` follows in the next cycle.
- `done` and `busy` are both high in the DONE cycle. `busy` falls the cycle after.
- Wait states: while `mem_ready=0`, `mem_addr`, `mem_write_enable`, and `read_reg_addrs` hold stable.
- Reset mid-operation: return to IDLE the next edge, discard remaining beats, perform no writeback.

## Configuration
- `BTS_BASE_WRITEBACK_EN` defined: WB state and W bit behave as above.
- Undefined:
  - The W bit is ignored and the WB state is not built.
  - XFER always goes to DONE after the last beat.
  - Latency is N+1 cycles to `done`.

## Structure
- Shared package `arm_pkg` holds:
  - `bts_state_t` enum.
  - `WORD_BYTES = 4`.
  - `PC_REG = 4'd15`.
  - `addr_mode_t` for {IA, IB, DA, DB}.
- Sub-module `lowest_set_bit`: 16-bit list in, 4-bit index out, plus a `none` flag. It is combinational and instantiated once. Popcount stays inline.

## Test plan
- STM IA: base=0x1000, list=0x000E, r1..r3=0xA,0xB,0xC, W=1 → writes 0xA@0x1000, 0xB@0x1004, 0xC@0x1008; r-base ← 0x100C; `done` at cycle 5.
- LDM DB: base=0x2000, list=0x8003 → reads 0x1FF4→r0, 0x1FF8→r1, 0x1FFC→`pc_load_valid`; `write_enable3` never targets r15.
- LDM IA with base in list, base_reg=2, list=0x0004, W=1 → r2 ← loaded value, no WB write.
- Empty list with W=1 → no `mem_req`; `done` at cycle 1; no register write.
- `mem_ready` low 3 cycles on beat 2 of a 3-register STM → address/data stable, total 6 beat cycles, order preserved.
- Reset asserted on beat 2 of a 4-register LDM → IDLE next edge, no further `write_enable3`, `busy=0`.
